// File: rtl/led_status_ctrl.sv
// Run/stop LED and motor-run sequencer: IDLE/RUN/FAULT FSM with tick prescaler,
// button dwell guard and FAULT blink. Optional LED_CTRL_AUTO_RESTART_EN resumes RUN after a clear.
module led_status_ctrl #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned BLINK_TICKS = 250,
    parameter int unsigned HOLD_TICKS  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       db_btn_i,
    input  logic       fault_i,
    input  logic       fault_clr_i,
    output logic       led_en_o,
    output logic       led_state_o,
    output logic       run_o,
    output logic [1:0] state_o
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned DWELL_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(HOLD_TICKS);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               btn_q;
    logic               led_state_q, led_state_d;
    logic               led_en_q, led_en_d;
    logic               run_q, run_d;
`ifdef LED_CTRL_AUTO_RESTART_EN
    logic               was_run_q, was_run_d;
`endif

    logic tick_s, btn_rise_s, dwell_ok_s, entry_s, blink_toggle_s;

    assign tick_s         = (presc_q == PRESC_MAX);
    assign btn_rise_s     = db_btn_i & ~btn_q;
    assign dwell_ok_s     = (dwell_q == DWELL_MAX);
    assign entry_s        = (state_d != state_q);
    assign blink_toggle_s = (state_q == ST_FAULT) && tick_s && (blink_q == BLINK_MAX);

    // Next-state selection; fault outranks any same-cycle button edge.
    always_comb begin
        state_d = state_q;
        if (fault_i) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_rise_s && dwell_ok_s) state_d = ST_RUN;
                    else                          state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (btn_rise_s && dwell_ok_s) state_d = ST_IDLE;
                    else                          state_d = ST_RUN;
                end
                ST_FAULT: begin
                    if (fault_clr_i) begin
`ifdef LED_CTRL_AUTO_RESTART_EN
                        state_d = was_run_q ? ST_RUN : ST_IDLE;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counter and output next values derived from the chosen next state.
    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : (presc_q + PRESC_ONE);

        if (entry_s)                             dwell_d = '0;
        else if (tick_s && (dwell_q != DWELL_MAX)) dwell_d = dwell_q + DWELL_ONE;
        else                                     dwell_d = dwell_q;

        if ((state_d != ST_FAULT) || entry_s || blink_toggle_s) blink_d = '0;
        else if (tick_s)                                        blink_d = blink_q + BLINK_ONE;
        else                                                    blink_d = blink_q;

        case (state_d)
            ST_RUN:   led_state_d = 1'b1;
            ST_IDLE:  led_state_d = 1'b0;
            ST_FAULT: begin
                if (entry_s)             led_state_d = 1'b0;
                else if (blink_toggle_s) led_state_d = ~led_state_q;
                else                     led_state_d = led_state_q;
            end
            default:  led_state_d = 1'b0;
        endcase

        run_d    = (state_d == ST_RUN);
        led_en_d = entry_s || (led_state_d != led_state_q);

`ifdef LED_CTRL_AUTO_RESTART_EN
        if (entry_s && (state_d == ST_FAULT)) was_run_d = (state_q == ST_RUN);
        else                                  was_run_d = was_run_q;
`endif
    end

    // State, counters and registered outputs; reset strobes led_en to force red.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            blink_q     <= '0;
            dwell_q     <= '0;
            btn_q       <= 1'b0;
            led_state_q <= 1'b0;
            led_en_q    <= 1'b1;
            run_q       <= 1'b0;
`ifdef LED_CTRL_AUTO_RESTART_EN
            was_run_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_q     <= blink_d;
            dwell_q     <= dwell_d;
            btn_q       <= db_btn_i;
            led_state_q <= led_state_d;
            led_en_q    <= led_en_d;
            run_q       <= run_d;
`ifdef LED_CTRL_AUTO_RESTART_EN
            was_run_q   <= was_run_d;
`endif
        end
    end

    assign state_o     = state_q;
    assign run_o       = run_q;
    assign led_state_o = led_state_q;
    assign led_en_o    = led_en_q;

endmodule
